fetch_seq: RTL and testbench
============================

# fetch_seq

Instruction fetch sequencer for the A3 core. Owns the fetch address and drives the 8-bit control bus to read the four bytes of each 32-bit instruction. Assembles them little-endian and presents the word to decode over a valid/ready handshake. Also accepts branch/trap redirects, squashing any fetch in flight.

## Interface
- `CTL_READ_ADDR`, default 8'h02: control-bus opcode for a byte read.
- `CTL_NOP`, default 8'h00: control-bus idle opcode.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset; clock `clk`.
- `bus_data_in` in 8: read data byte.
- `bus_valid` in 1: `bus_data_in` holds the response to the last issued read.
- `redirect_valid` in 1: load a new fetch address.
- `redirect_addr` in 17: new fetch address.
- `insn_ready` in 1: decode accepts the instruction.
- `ctl_op_out` out 8: control-bus opcode.
- `ctl_data_out` out 64: byte address, zero-extended from 17 bits.
- `insn_valid` out 1: instruction word available.
- `insn_data` out 32: assembled instruction.
- `insn_addr` out 17: address of byte 0 of `insn_data`.
- `misalign_fault` out 1: one-cycle pulse. Exists only under the configuration macro.

## Operation
- Registers:
  - `fetch_addr[16:0]`.
  - Byte index `k[1:0]`.
  - Assembly register `[31:0]`.
  - State.
- States:
  - REQ: issue a read.
  - WAIT: await `bus_valid`.
  - HOLD: present the instruction.
  - DRAIN: discard a squashed response.
- REQ:
  - `ctl_op_out=CTL_READ_ADDR`.
  - `ctl_data_out={47'b0, fetch_addr+k}`; the sum wraps in 17 bits.
  - Next state: WAIT.
- WAIT:
  - `ctl_op_out=CTL_NOP`.
  - On `bus_valid`, store the byte at bits [8k+7:8k].
  - If k<3: k+=1, next state REQ.
  - If k==3: k=0, register `insn_valid=1`, `insn_addr=fetch_addr`, next state HOLD.
- HOLD:
  - Outputs are stable while `insn_valid && !insn_ready`.
  - Transfer occurs when `insn_valid && insn_ready`.
  - On transfer: `fetch_addr+=4` (17-bit wrap, 0x1FFFC→0x00000), `insn_valid=0`, next state REQ.
- Redirect has top priority in every state:
  - `fetch_addr=redirect_addr`, k=0, `insn_valid=0`.
  - From WAIT with no `bus_valid` that cycle, the next state is DRAIN; otherwise it is REQ.
- DRAIN:
  - `ctl_op_out=CTL_NOP`; waits for `bus_valid`, discards the byte, next state REQ.
  - A further redirect in DRAIN updates `fetch_addr` and stays in DRAIN.
- Redirect and HOLD transfer in the same cycle: the transfer completes (decode keeps the word) and the redirect address is used, not +4.
- `bus_valid` outside WAIT and DRAIN is ignored.

## Timing
- During reset:
  - `ctl_op_out=0`, `ctl_data_out=0`, `insn_valid=0`, `insn_data=0`, `insn_addr=0`, `misalign_fault=0`.
  - `fetch_addr=0`, k=0, state REQ.
- Reset mid-operation abandons everything with no drain; the bus is required to be reset in the same cycle.
- First read is issued in the first cycle after reset deasserts.
- All outputs are registered.
- Best case, a zero-wait bus (`bus_valid` the cycle after REQ):
  - 8 cycles from the first REQ to `insn_valid`.
  - 9 cycles per instruction with `insn_ready` held high.
- Redirect seen in cycle N → REQ to `redirect_addr` in cycle N+1, unless draining.

## Configuration
- `FETCH_SEQ_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_addr[1:0]!=0` is ignored and pulses `misalign_fault` for one cycle.
  - Sequencing continues unchanged.
- Undefined:
  - No `misalign_fault` port.
  - Any redirect address is accepted and bytes are fetched from it unaligned.

## Structure
- Package `a3_ctl_pkg`:
  - `CTL_NOP` and `CTL_READ_ADDR` constants.
  - The `fetch_state_t` enum (REQ/WAIT/HOLD/DRAIN).
  - `ADDR_W=17`.
  - This package is shared with the pc and future bus agents.
- Sub-module `byte_asm`: a 4-byte lane-indexed assembly register with load-enable and clear. All other logic stays in `fetch_seq`.

## Test plan
- Reset then zero-wait bus returning 0x13,0x00,0x50,0xA0:
  - Reads issued at addresses 0,1,2,3.
  - `insn_valid` with `insn_data=0xA0500013`, `insn_addr=0`.
  - Next REQ is to address 4.
- `insn_ready` held low for 5 cycles: `insn_valid`/`insn_data` are stable and no new REQ is issued. Raising `insn_ready` gives one transfer.
- Redirect to 0x00100 while in WAIT for byte 1:
  - DRAIN discards the pending response.
  - Next REQ address is 0x00100.
  - The old partial word is never presented.
- Redirect to 0x00040 in the same cycle as a HOLD transfer at 0x00008: the transfer counts and the next REQ is 0x00040, not 0x0000C.
- `fetch_addr=0x1FFFC`:
  - Bytes are read at 0x1FFFC–0x1FFFF.
  - After transfer, the next REQ is 0x00000.
  - `ctl_data_out[63:17]` is always 0.
- With `FETCH_SEQ_ALIGN_CHECK_EN`, redirect to 0x00042:
  - `misalign_fault` pulses once.
  - Fetch continues at the prior sequential address.

Source files
------------

// File: rtl/a3_ctl_pkg.sv
// rtl/a3_ctl_pkg.sv - A3 control-bus opcodes, fetch FSM states and address width
package a3_ctl_pkg;

   localparam int ADDR_W = 17;

   localparam logic [7:0] CTL_NOP       = 8'h00;
   localparam logic [7:0] CTL_READ_ADDR = 8'h02;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/byte_asm.sv
// rtl/byte_asm.sv - 4-byte lane-indexed assembly register with load-enable and clear
module byte_asm (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load,
   input  logic [1:0]  lane,
   input  logic [7:0]  data,
   output logic [31:0] word
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word <= '0;
      end else if (load) begin
         word[{lane, 3'b000} +: 8] <= data;
      end
   end

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - A3 instruction fetch sequencer; FETCH_SEQ_ALIGN_CHECK_EN rejects misaligned redirects
module fetch_seq
   import a3_ctl_pkg::*;
#(
   parameter logic [7:0] CTL_READ_ADDR = a3_ctl_pkg::CTL_READ_ADDR,
   parameter logic [7:0] CTL_NOP       = a3_ctl_pkg::CTL_NOP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  bus_data_in,
   input  logic        bus_valid,
   input  logic        redirect_valid,
   input  logic [16:0] redirect_addr,
   input  logic        insn_ready,
   output logic [7:0]  ctl_op_out,
   output logic [63:0] ctl_data_out,
   output logic        insn_valid,
   output logic [31:0] insn_data,
   output logic [16:0] insn_addr
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
   ,
   output logic        misalign_fault
`endif
);

   fetch_state_t        state;
   logic [ADDR_W-1:0]   fetch_addr;
   logic [1:0]          k;
   logic [ADDR_W-1:0]   ctl_addr;
   logic [31:0]         asm_word;
   logic                redirect_take;
   logic                asm_load;

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned    = redirect_valid && (redirect_addr[1:0] != 2'b00);
   assign redirect_take = redirect_valid && !misaligned;
`else
   assign redirect_take = redirect_valid;
`endif

   assign ctl_data_out = {47'b0, ctl_addr};
   assign asm_load     = (state == WAIT) && bus_valid && !redirect_take;

   byte_asm u_byte_asm (
      .clk   (clk),
      .reset (reset),
      .clear (redirect_take),
      .load  (asm_load),
      .lane  (k),
      .data  (bus_data_in),
      .word  (asm_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= REQ;
         fetch_addr <= '0;
         k          <= '0;
         ctl_op_out <= '0;
         ctl_addr   <= '0;
         insn_valid <= 1'b0;
         insn_data  <= '0;
         insn_addr  <= '0;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
         misalign_fault <= 1'b0;
`endif
      end else begin
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
         misalign_fault <= misaligned;
`endif
         if (redirect_take) begin
            fetch_addr <= redirect_addr;
            k          <= '0;
            insn_valid <= 1'b0;
            // A read is still outstanding unless its response lands this cycle
            if ((state == WAIT || state == DRAIN) && !bus_valid) begin
               state      <= DRAIN;
               ctl_op_out <= CTL_NOP;
            end else begin
               state      <= REQ;
               ctl_op_out <= CTL_READ_ADDR;
               ctl_addr   <= redirect_addr;
            end
         end else begin
            case (state)
               REQ: begin
                  // Only the first REQ after reset arrives without its read already on the bus
                  if (ctl_op_out == CTL_READ_ADDR) begin
                     state      <= WAIT;
                     ctl_op_out <= CTL_NOP;
                  end else begin
                     ctl_op_out <= CTL_READ_ADDR;
                     ctl_addr   <= fetch_addr + {15'b0, k};
                  end
               end
               WAIT: begin
                  if (bus_valid) begin
                     if (k == 2'd3) begin
                        k          <= '0;
                        insn_valid <= 1'b1;
                        insn_data  <= {bus_data_in, asm_word[23:0]};
                        insn_addr  <= fetch_addr;
                        state      <= HOLD;
                     end else begin
                        k          <= k + 2'd1;
                        state      <= REQ;
                        ctl_op_out <= CTL_READ_ADDR;
                        ctl_addr   <= fetch_addr + {15'b0, k} + 17'd1;
                     end
                  end
               end
               HOLD: begin
                  if (insn_ready) begin
                     insn_valid <= 1'b0;
                     fetch_addr <= fetch_addr + 17'd4;
                     state      <= REQ;
                     ctl_op_out <= CTL_READ_ADDR;
                     ctl_addr   <= fetch_addr + 17'd4;
                  end
               end
               DRAIN: begin
                  if (bus_valid) begin
                     state      <= REQ;
                     ctl_op_out <= CTL_READ_ADDR;
                     ctl_addr   <= fetch_addr;
                  end
               end
               default: state <= REQ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - self-checking bench for fetch_seq
module tb_fetch_seq;

   localparam logic [7:0] OP_RD  = 8'h02;
   localparam logic [7:0] OP_NOP = 8'h00;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  bus_data_in;
   logic        bus_valid;
   logic        redirect_valid;
   logic [16:0] redirect_addr;
   logic        insn_ready;
   logic [7:0]  ctl_op_out;
   logic [63:0] ctl_data_out;
   logic        insn_valid;
   logic [31:0] insn_data;
   logic [16:0] insn_addr;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
   logic        misalign_fault;
`endif

   int checks = 0;
   int errors = 0;
   int xfers  = 0;

   always #5 clk = ~clk;

   fetch_seq dut (
      .clk            (clk),
      .reset          (reset),
      .bus_data_in    (bus_data_in),
      .bus_valid      (bus_valid),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .insn_ready     (insn_ready),
      .ctl_op_out     (ctl_op_out),
      .ctl_data_out   (ctl_data_out),
      .insn_valid     (insn_valid),
      .insn_data      (insn_data),
      .insn_addr      (insn_addr)
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
      ,
      .misalign_fault (misalign_fault)
`endif
   );

   always @(posedge clk) begin
      if (!reset && insn_valid && insn_ready) xfers++;
   end

   typedef struct {
      logic        rst;
      logic        bv;
      logic [7:0]  bd;
      logic        rdy;
      logic [7:0]  op;
      logic        chk_addr;
      logic [16:0] addr;
      logic        valid;
      logic        chk_word;
      logic [31:0] data;
      logic [16:0] iaddr;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic bv, input logic [7:0] bd, input logic rv,
                       input logic [16:0] ra, input logic rdy);
      bus_valid      = bv;
      bus_data_in    = bd;
      redirect_valid = rv;
      redirect_addr  = ra;
      insn_ready     = rdy;
      @(posedge clk);
      #1;
      bus_valid      = 1'b0;
      redirect_valid = 1'b0;
   endtask

   // Expects to be called with a REQ for base visible; leaves the word in HOLD
   task automatic fetch_word(input logic [16:0] base, input logic [31:0] w, input logic rdy);
      logic [16:0] a;
      for (int i = 0; i < 4; i++) begin
         a = base + 17'(i);
         chk($sformatf("fw_op_rd[%0d]", i), 64'(ctl_op_out), 64'(OP_RD));
         chk($sformatf("fw_addr[%0d]", i), ctl_data_out, {47'b0, a});
         chk($sformatf("fw_hi_zero[%0d]", i), 64'(ctl_data_out[63:17]), 64'd0);
         chk($sformatf("fw_no_valid[%0d]", i), 64'(insn_valid), 64'd0);
         step(1'b0, 8'h00, 1'b0, 17'h0, rdy);
         chk($sformatf("fw_op_nop[%0d]", i), 64'(ctl_op_out), 64'(OP_NOP));
         step(1'b1, w[8*i +: 8], 1'b0, 17'h0, rdy);
      end
      chk("fw_valid", 64'(insn_valid), 64'd1);
      chk("fw_data", 64'(insn_data), 64'(w));
      chk("fw_iaddr", 64'(insn_addr), 64'(base));
   endtask

   initial begin
      reset = 1'b1; bus_valid = 1'b0; bus_data_in = 8'h00;
      redirect_valid = 1'b0; redirect_addr = 17'h0; insn_ready = 1'b0;

      //            rst   bv    bd     rdy   op      chka  addr    v     chkw  data          iaddr
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b1, 17'h0, 1'b0, 1'b1, 32'h0,        17'h0};
      vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b1, 17'h0, 1'b0, 1'b1, 32'h0,        17'h0};
      vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, OP_RD,  1'b1, 17'h0, 1'b0, 1'b0, 32'h0,        17'h0};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b0, 1'b0, 32'h0,        17'h0};
      vecs[4]  = '{1'b0, 1'b1, 8'h13, 1'b0, OP_RD,  1'b1, 17'h1, 1'b0, 1'b0, 32'h0,        17'h0};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b0, 1'b0, 32'h0,        17'h0};
      vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, OP_RD,  1'b1, 17'h2, 1'b0, 1'b0, 32'h0,        17'h0};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b0, 1'b0, 32'h0,        17'h0};
      vecs[8]  = '{1'b0, 1'b1, 8'h50, 1'b0, OP_RD,  1'b1, 17'h3, 1'b0, 1'b0, 32'h0,        17'h0};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b0, 1'b0, 32'h0,        17'h0};
      vecs[10] = '{1'b0, 1'b1, 8'hA0, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b1, 1'b1, 32'hA0500013, 17'h0};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b1, 1'b1, 32'hA0500013, 17'h0};
      vecs[12] = '{1'b0, 1'b1, 8'hFF, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b1, 1'b1, 32'hA0500013, 17'h0};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b1, 1'b1, 32'hA0500013, 17'h0};
      vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b1, 1'b1, 32'hA0500013, 17'h0};
      vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, OP_NOP, 1'b0, 17'h0, 1'b1, 1'b1, 32'hA0500013, 17'h0};
      vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, OP_RD,  1'b1, 17'h4, 1'b0, 1'b0, 32'h0,        17'h0};

      for (int i = 0; i < 17; i++) begin
         reset       = vecs[i].rst;
         bus_valid   = vecs[i].bv;
         bus_data_in = vecs[i].bd;
         insn_ready  = vecs[i].rdy;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_op", i), 64'(ctl_op_out), 64'(vecs[i].op));
         if (vecs[i].chk_addr)
            chk($sformatf("vec%0d_addr", i), ctl_data_out, {47'b0, vecs[i].addr});
         chk($sformatf("vec%0d_valid", i), 64'(insn_valid), 64'(vecs[i].valid));
         if (vecs[i].chk_word) begin
            chk($sformatf("vec%0d_data", i), 64'(insn_data), 64'(vecs[i].data));
            chk($sformatf("vec%0d_iaddr", i), 64'(insn_addr), 64'(vecs[i].iaddr));
         end
      end
      bus_valid = 1'b0;
      insn_ready = 1'b0;
      chk("xfer_after_hold", 64'(xfers), 64'd1);

      // Redirect while waiting for byte 1 at address 5
      step(1'b0, 8'h00, 1'b0, 17'h0, 1'b0);
      chk("w4_op_nop", 64'(ctl_op_out), 64'(OP_NOP));
      step(1'b1, 8'h11, 1'b0, 17'h0, 1'b0);
      chk("w4_req5", ctl_data_out, 64'h5);
      step(1'b0, 8'h00, 1'b0, 17'h0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 17'h00100, 1'b0);
      chk("drain_op", 64'(ctl_op_out), 64'(OP_NOP));
      chk("drain_valid", 64'(insn_valid), 64'd0);
      step(1'b0, 8'h00, 1'b0, 17'h0, 1'b0);
      chk("drain_hold_op", 64'(ctl_op_out), 64'(OP_NOP));
      step(1'b1, 8'hEE, 1'b0, 17'h0, 1'b0);
      fetch_word(17'h00100, 32'hDEADBEEF, 1'b0);

      // Redirect out of HOLD without transfer, then redirect coinciding with a transfer
      step(1'b0, 8'h00, 1'b1, 17'h00008, 1'b0);
      chk("hold_redir_valid", 64'(insn_valid), 64'd0);
      fetch_word(17'h00008, 32'h00C58593, 1'b0);
      step(1'b0, 8'h00, 1'b1, 17'h00040, 1'b1);
      chk("xfer_redir_op", 64'(ctl_op_out), 64'(OP_RD));
      chk("xfer_redir_addr", ctl_data_out, 64'h40);
      chk("xfer_redir_valid", 64'(insn_valid), 64'd0);
      chk("xfer_redir_count", 64'(xfers), 64'd2);

      // Address wrap at the top of the 17-bit space, 9 cycles per word with ready high
      step(1'b0, 8'h00, 1'b1, 17'h1FFFC, 1'b1);
      fetch_word(17'h1FFFC, 32'h12345678, 1'b1);
      step(1'b0, 8'h00, 1'b0, 17'h0, 1'b1);
      chk("wrap_op", 64'(ctl_op_out), 64'(OP_RD));
      chk("wrap_addr", ctl_data_out, 64'h0);
      chk("wrap_count", 64'(xfers), 64'd3);

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
      step(1'b0, 8'h00, 1'b1, 17'h00042, 1'b0);
      chk("mis_fault", 64'(misalign_fault), 64'd1);
      chk("mis_op_nop", 64'(ctl_op_out), 64'(OP_NOP));
      step(1'b1, 8'h01, 1'b0, 17'h0, 1'b0);
      chk("mis_fault_clr", 64'(misalign_fault), 64'd0);
      chk("mis_seq_addr", ctl_data_out, 64'h1);
`else
      step(1'b0, 8'h00, 1'b1, 17'h00042, 1'b0);
      chk("unal_op", 64'(ctl_op_out), 64'(OP_RD));
      chk("unal_addr", ctl_data_out, 64'h42);
`endif

      // Reset mid-operation
      reset = 1'b1;
      step(1'b0, 8'h00, 1'b0, 17'h0, 1'b0);
      chk("rst_op", 64'(ctl_op_out), 64'd0);
      chk("rst_addr", ctl_data_out, 64'd0);
      chk("rst_valid", 64'(insn_valid), 64'd0);
      reset = 1'b0;
      step(1'b0, 8'h00, 1'b0, 17'h0, 1'b0);
      chk("rst_first_op", 64'(ctl_op_out), 64'(OP_RD));
      chk("rst_first_addr", ctl_data_out, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
